// File: rtl/regfile_wb_queue.sv
// Write-back request queue in front of the register file write ports.
// Buffers E/M writes, drains one entry per enabled cycle, and forwards pending values to decode.
module regfile_wb_queue #(
  parameter int                  DATA_WID = 32,
  parameter int                  ADDR_WID = 4,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDR_WID-1:0] RNONE    = 4'hF
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WID-1:0]          in_destE,
  input  logic [DATA_WID-1:0]          in_valE,
  input  logic [ADDR_WID-1:0]          in_destM,
  input  logic [DATA_WID-1:0]          in_valM,
  input  logic                         wb_en,
  output logic [ADDR_WID-1:0]          destE,
  output logic [DATA_WID-1:0]          valE,
  output logic [ADDR_WID-1:0]          destM,
  output logic [DATA_WID-1:0]          valM,
  input  logic [ADDR_WID-1:0]          srcA,
  input  logic [ADDR_WID-1:0]          srcB,
  output logic                         fwdA_hit,
  output logic [DATA_WID-1:0]          fwdA_val,
  output logic                         fwdB_hit,
  output logic [DATA_WID-1:0]          fwdB_val,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [ADDR_WID-1:0] dest_e_r [DEPTH];
  logic [DATA_WID-1:0] val_e_r  [DEPTH];
  logic [ADDR_WID-1:0] dest_m_r [DEPTH];
  logic [DATA_WID-1:0] val_m_r  [DEPTH];
  logic [PW-1:0]       rd_ptr_r;
  logic [PW-1:0]       wr_ptr_r;
  logic [CW-1:0]       count_r;

  logic                empty_s;
  logic                pop_s;
  logic                accept_s;
  logic                store_s;
  logic [DATA_WID:0]   fwd_a_s;
  logic [DATA_WID:0]   fwd_b_s;

  // Walk oldest to youngest so the youngest match overwrites; M beats E inside one entry.
  function automatic logic [DATA_WID:0] fwd_lookup(input logic [ADDR_WID-1:0] src);
    logic [DATA_WID:0] res;
    logic [PW-1:0]     idx;
    res = {(DATA_WID+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_r + PW'(i);
      if ((src != RNONE) && (CW'(i) < count_r)) begin
        if (dest_m_r[idx] == src) begin
          res = {1'b1, val_m_r[idx]};
        end else if (dest_e_r[idx] == src) begin
          res = {1'b1, val_e_r[idx]};
        end else begin
          res = res;
        end
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign empty_s  = (count_r == {CW{1'b0}});
  assign in_ready = (count_r < CW'(DEPTH)) || (wb_en && !empty_s);
  assign accept_s = in_valid && in_ready;
  // Requests targeting no register are acknowledged but never occupy a slot.
  assign store_s  = accept_s && !((in_destE == RNONE) && (in_destM == RNONE));
  assign pop_s    = RST_N && wb_en && !empty_s;
  assign count    = count_r;

  // Head presentation; idle cycles must show RNONE because the register file writes every edge.
  always_comb begin
    destE = RNONE;
    valE  = {DATA_WID{1'b0}};
    destM = RNONE;
    valM  = {DATA_WID{1'b0}};
    if (pop_s) begin
      destE = dest_e_r[rd_ptr_r];
      valE  = val_e_r[rd_ptr_r];
      destM = dest_m_r[rd_ptr_r];
      valM  = val_m_r[rd_ptr_r];
    end else begin
      destE = RNONE;
    end
  end

  // Forwarding lookups for both decode read ports.
  always_comb begin
    fwd_a_s  = fwd_lookup(srcA);
    fwd_b_s  = fwd_lookup(srcB);
    fwdA_hit = fwd_a_s[DATA_WID];
    fwdA_val = fwd_a_s[DATA_WID-1:0];
    fwdB_hit = fwd_b_s[DATA_WID];
    fwdB_val = fwd_b_s[DATA_WID-1:0];
  end

  // Entry storage; contents are only meaningful below count_r, so no reset needed.
  always_ff @(posedge CLK) begin
    if (store_s) begin
      dest_e_r[wr_ptr_r] <= in_destE;
      val_e_r[wr_ptr_r]  <= in_valE;
      dest_m_r[wr_ptr_r] <= in_destM;
      val_m_r[wr_ptr_r]  <= in_valM;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({store_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus a scoreboard
// that tracks every stored request and compares drains, count, ready and forwarding.
module tb_regfile_wb_queue;

  localparam int         DW    = 32;
  localparam int         AW    = 4;
  localparam int         DEPTH = 4;
  localparam int         CW    = 3;
  localparam logic [3:0] RN    = 4'hF;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_destE, in_destM, destE, destM, srcA, srcB;
  logic [DW-1:0] in_valE, in_valM, valE, valM, fwdA_val, fwdB_val;
  logic          wb_en, fwdA_hit, fwdB_hit;
  logic [CW-1:0] count;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  typedef struct packed {
    logic [AW-1:0] de;
    logic [DW-1:0] ve;
    logic [AW-1:0] dm;
    logic [DW-1:0] vm;
  } ent_t;

  ent_t exp_q[$];

  regfile_wb_queue #(.DATA_WID(DW), .ADDR_WID(AW), .DEPTH(DEPTH), .RNONE(RN)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_destE(in_destE), .in_valE(in_valE), .in_destM(in_destM), .in_valM(in_valM),
    .wb_en(wb_en),
    .destE(destE), .valE(valE), .destM(destM), .valM(valM),
    .srcA(srcA), .srcB(srcB),
    .fwdA_hit(fwdA_hit), .fwdA_val(fwdA_val), .fwdB_hit(fwdB_hit), .fwdB_val(fwdB_val),
    .count(count)
  );

  always #5 CLK = ~CLK;

  // Reference forwarding: youngest entry first, destM before destE.
  function automatic logic [DW:0] model_fwd(input logic [AW-1:0] src);
    if (src == RN) return {(DW+1){1'b0}};
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].dm == src) return {1'b1, exp_q[i].vm};
      if (exp_q[i].de == src) return {1'b1, exp_q[i].ve};
    end
    return {(DW+1){1'b0}};
  endfunction

  int         sz;
  logic       exp_rdy;
  logic       exp_pop;
  ent_t       exp_out;
  logic [DW:0] exp_fa, exp_fb;

  // Scoreboard monitor, sampled mid-cycle on the falling edge.
  always @(negedge CLK) begin
    if (mon_en) begin
      sz      = exp_q.size();
      exp_rdy = (sz < DEPTH) || (wb_en && sz != 0);
      exp_pop = RST_N && wb_en && (sz != 0);
      exp_out = exp_pop ? exp_q[0] : {RN, {DW{1'b0}}, RN, {DW{1'b0}}};
      exp_fa  = model_fwd(srcA);
      exp_fb  = model_fwd(srcB);
      checks++;
      if (count !== sz[CW-1:0]) begin
        failures++; $display("FAIL sb_count t=%0t actual=%0d expected=%0d", $time, count, sz);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
        failures++; $display("FAIL sb_in_ready t=%0t actual=%0b expected=%0b", $time, in_ready, exp_rdy);
      end
      checks++;
      if ({destE, valE, destM, valM} !== exp_out) begin
        failures++;
        $display("FAIL sb_write t=%0t actual=%h/%h/%h/%h expected=%h/%h/%h/%h", $time,
                 destE, valE, destM, valM, exp_out.de, exp_out.ve, exp_out.dm, exp_out.vm);
      end
      checks++;
      if ({fwdA_hit, fwdA_val} !== exp_fa || {fwdB_hit, fwdB_val} !== exp_fb) begin
        failures++;
        $display("FAIL sb_fwd t=%0t actual=%b:%h %b:%h expected=%b:%h %b:%h", $time,
                 fwdA_hit, fwdA_val, fwdB_hit, fwdB_val, exp_fa[DW], exp_fa[DW-1:0], exp_fb[DW], exp_fb[DW-1:0]);
      end
      if (!RST_N) begin
        exp_q.delete();
      end else begin
        if (exp_pop) void'(exp_q.pop_front());
        if (in_valid && exp_rdy && !(in_destE == RN && in_destM == RN))
          exp_q.push_back({in_destE, in_valE, in_destM, in_valM});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit v, input logic [AW-1:0] de, input logic [DW-1:0] ve,
                       input logic [AW-1:0] dm, input logic [DW-1:0] vm);
    in_valid = v; in_destE = de; in_valE = ve; in_destM = dm; in_valM = vm;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; wb_en = 1'b0; srcA = 4'd0; srcB = 4'd0;
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    repeat (2) step();
    RST_N = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count actual=%0d expected=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%0b expected=1", in_ready); end
    checks++; if (destE !== RN || destM !== RN || valE !== 32'h0 || valM !== 32'h0) begin
      failures++; $display("FAIL reset_ports actual=%h/%h/%h/%h expected=f/0/f/0", destE, valE, destM, valM); end
    checks++; if (fwdA_hit !== 1'b0 || fwdB_hit !== 1'b0 || fwdA_val !== 32'h0 || fwdB_val !== 32'h0) begin
      failures++; $display("FAIL reset_fwd actual=%b/%b expected=0/0", fwdA_hit, fwdB_hit); end
    step();
    wb_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (destE !== RN || destM !== RN) begin
        failures++; $display("FAIL idle_ports actual=%h/%h expected=f/f", destE, destM); end
      step();
    end
  endtask

  task automatic test_single();
    wb_en = 1'b1;
    drive(1'b1, 4'd2, 32'h11, RN, 32'h0);
    step();
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    @(negedge CLK);
    checks++; if (destE !== 4'd2 || valE !== 32'h11 || destM !== RN) begin
      failures++; $display("FAIL single_write actual=%h/%h/%h expected=2/11/f", destE, valE, destM); end
    step();
    @(negedge CLK);
    checks++; if (count !== 3'd0 || destE !== RN) begin
      failures++; $display("FAIL single_drained actual=%0d/%h expected=0/f", count, destE); end
    step();
  endtask

  task automatic test_back_to_back();
    wb_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 4'(k), 32'hA0 + 32'(k), RN, 32'h0);
      step();
    end
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    @(negedge CLK);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      failures++; $display("FAIL full_state actual=%0d/%0b expected=4/0", count, in_ready); end
    step();
    drive(1'b1, 4'd5, 32'hA5, RN, 32'h0);
    wb_en = 1'b1;
    @(negedge CLK);
    checks++; if (in_ready !== 1'b1 || destE !== 4'd1) begin
      failures++; $display("FAIL full_pushpop actual=%0b/%h expected=1/1", in_ready, destE); end
    step();
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge CLK);
      checks++; if (destE !== 4'(k) || valE !== 32'hA0 + 32'(k)) begin
        failures++; $display("FAIL drain_order actual=%h/%h expected=%h/%h", destE, valE, k, 32'hA0 + k); end
      if (k == 2) begin
        checks++; if (count !== 3'd4) begin
          failures++; $display("FAIL full_count_hold actual=%0d expected=4", count); end
      end
      step();
    end
    @(negedge CLK);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_empty actual=%0d expected=0", count); end
    step();
  endtask

  task automatic test_forward();
    wb_en = 1'b0;
    drive(1'b1, 4'd3, 32'h30, RN, 32'h0);   step();
    drive(1'b1, 4'd3, 32'h31, RN, 32'h0);   step();
    drive(1'b1, 4'd6, 32'h60, 4'd6, 32'h61); step();
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    srcA = 4'd3; srcB = 4'd6;
    @(negedge CLK);
    checks++; if (fwdA_hit !== 1'b1 || fwdA_val !== 32'h31) begin
      failures++; $display("FAIL fwd_youngest actual=%b/%h expected=1/31", fwdA_hit, fwdA_val); end
    checks++; if (fwdB_hit !== 1'b1 || fwdB_val !== 32'h61) begin
      failures++; $display("FAIL fwd_m_prio actual=%b/%h expected=1/61", fwdB_hit, fwdB_val); end
    step();
    srcA = RN; srcB = 4'd4;
    @(negedge CLK);
    checks++; if (fwdA_hit !== 1'b0 || fwdA_val !== 32'h0 || fwdB_hit !== 1'b0) begin
      failures++; $display("FAIL fwd_miss actual=%b/%h/%b expected=0/0/0", fwdA_hit, fwdA_val, fwdB_hit); end
    step();
    srcB = 4'd6; wb_en = 1'b1;
    repeat (2) step();
    @(negedge CLK);
    checks++; if (fwdB_hit !== 1'b1 || fwdB_val !== 32'h61 || destM !== 4'd6) begin
      failures++; $display("FAIL fwd_head_pop actual=%b/%h/%h expected=1/61/6", fwdB_hit, fwdB_val, destM); end
    step();
    srcA = 4'd0; srcB = 4'd0;
  endtask

  task automatic test_null_push();
    wb_en = 1'b0;
    drive(1'b1, RN, 32'h55, RN, 32'h66);
    @(negedge CLK);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL null_ready actual=%0b expected=1", in_ready); end
    step();
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    wb_en = 1'b1;
    @(negedge CLK);
    checks++; if (count !== 3'd0 || destE !== RN || destM !== RN) begin
      failures++; $display("FAIL null_stored actual=%0d/%h/%h expected=0/f/f", count, destE, destM); end
    step();
  endtask

  task automatic test_reset_mid();
    wb_en = 1'b0;
    drive(1'b1, 4'd8, 32'h80, RN, 32'h0);   step();
    drive(1'b1, 4'd9, 32'h90, RN, 32'h0);   step();
    drive(1'b1, RN, 32'h0, 4'd10, 32'hA0);  step();
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    srcA = 4'd9; srcB = 4'd10;
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    @(negedge CLK);
    checks++; if (count !== 3'd0 || destE !== RN || destM !== RN) begin
      failures++; $display("FAIL rst_mid_state actual=%0d/%h/%h expected=0/f/f", count, destE, destM); end
    checks++; if (fwdA_hit !== 1'b0 || fwdB_hit !== 1'b0) begin
      failures++; $display("FAIL rst_mid_fwd actual=%b/%b expected=0/0", fwdA_hit, fwdB_hit); end
    step();
    wb_en = 1'b1;
    repeat (4) step();
  endtask

  task automatic test_random();
    logic [AW-1:0] de, dm;
    for (int i = 0; i < 500; i++) begin
      de = ($urandom_range(0, 3) == 0) ? RN : 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), de, $urandom, dm, $urandom);
      wb_en = 1'($urandom_range(0, 2) != 0);
      srcA  = 4'($urandom_range(0, 15));
      srcB  = 4'($urandom_range(0, 15));
      step();
    end
    drive(1'b0, RN, 32'h0, RN, 32'h0);
    wb_en = 1'b1;
    repeat (DEPTH + 2) step();
    @(negedge CLK);
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL random_drain actual=%0d expected=0", count); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_forward();
    test_null_push();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writer-side companion to the CPU register file. It buffers retiring write-back requests (destE/valE, destM/valM) from the pipeline in a small FIFO.
- Drains one request per enabled cycle onto the register file's two write ports.
- Exposes pending-write forwarding for two read addresses, so decode sees values that are not yet written.
- Sits between the write-back stage and the register file write ports.

Parameters:
- DATA_WID, 32, register data width.
- ADDR_WID, 4, register address width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- RNONE, 4'hF, "no register" address; writes to it are discarded by the register file.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST_N  in  1  synchronous active-low reset.
- in_valid  in  1  write-back request present.
- in_ready  out  1  queue can accept a request this cycle.
- in_destE  in  ADDR_WID  E destination.
- in_valE  in  DATA_WID  E value.
- in_destM  in  ADDR_WID  M destination.
- in_valM  in  DATA_WID  M value.
- wb_en  in  1  register file write ports available this cycle.
- destE  out  ADDR_WID  to register file destE.
- valE  out  DATA_WID  to register file valE.
- destM  out  ADDR_WID  to register file destM.
- valM  out  DATA_WID  to register file valM.
- srcA  in  ADDR_WID  forwarding lookup A.
- srcB  in  ADDR_WID  forwarding lookup B.
- fwdA_hit  out  1  pending write to srcA exists.
- fwdA_val  out  DATA_WID  youngest pending value for srcA.
- fwdB_hit  out  1  same for srcB.
- fwdB_val  out  DATA_WID  same for srcB.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (RST_N=0 at edge): rd/wr pointers and count cleared; all entries invalid. After reset:
  - count=0, in_ready=1.
  - destE=destM=RNONE, valE=valM=0.
  - fwd*_hit=0, fwd*_val=0.
- Reset mid-operation discards all queued writes; no further write reaches the register file.
- Write ports (combinational from head):
  - If !empty && wb_en: head entry drives destE/valE/destM/valM and is popped at the same edge the register file captures it.
  - Otherwise: destE=destM=RNONE, valE=valM=0. The register file writes every edge, so idle cycles must never present a real address.
- Push: occurs at the edge when in_valid && in_ready.
  - A request with in_destE==RNONE and in_destM==RNONE is accepted but not stored; count is unchanged by it.
- in_ready = (count<DEPTH) || (wb_en && count!=0). Push and pop in the same cycle when full are allowed; count stays DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- Empty queue with push and wb_en: the new entry is not bypassed to the write ports. It drains no earlier than the next cycle (1-cycle minimum latency).
- Ordering: strict FIFO. E and M of one entry are written in the same cycle.
- Forwarding (combinational):
  - Search all valid entries, including the head being popped this cycle; exclude the incoming request.
  - srcX==RNONE: never a hit.
  - Youngest matching entry wins.
  - Within one entry, a destM match takes priority over a destE match (M written last).
  - On no hit, fwd*_val=0.

Test Plan:
- Reset, then idle with wb_en=1 -> destE=destM=4'hF every cycle, count=0, in_ready=1.
- Push {destE=2, valE=0x11, destM=F}, wb_en=1 -> next cycle destE=2, valE=0x11, destM=F; following cycle count=0, outputs idle.
- wb_en=0, push 4 entries with destE=1..4 and valE=0xA1..0xA4 -> count=4, in_ready=0. Raise wb_en with in_valid held (destE=5) -> pop and push together, count stays 4, drain order 1,2,3,4,5.
- Queue {destE=3, valE=0x30}, then {destE=3, valE=0x31}, srcA=3 -> fwdA_hit=1, fwdA_val=0x31. Entry {destE=6, valE=0x60, destM=6, valM=0x61}, srcB=6 -> fwdB_val=0x61. srcA=F -> fwdA_hit=0.
- Push {destE=F, destM=F} -> in_ready=1, count unchanged, nothing written.
- Fill 3 entries, assert RST_N=0 for one edge -> count=0, destE=destM=F, fwd hits cleared, no queued value ever appears on the write ports.
